uart_tx_frame: RTL

Parametrised UART transmitter that serialises one word per frame onto `uart_txd`, LSB first: start bit, 5–9 data bits, optional even/odd parity bit, then 1 or 2 stop bits. The bit period is a compile-time divider of the system clock. Words are accepted over a valid/ready handshake and latched at acceptance, so upstream may change `tx_data` immediately afterwards. It sits between a byte source (FIFO or command engine) and the board TX pin. It is the successor to the fixed 8N1 transmitter.

---
 rtl/uart_tx_frame.sv | 106 ++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter with start bit, 5-9 data bits LSB first, optional parity, 1-2 stop bits.
module uart_tx_frame #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 100000,
    parameter int DIV        = CLK_FREQ / BAUD_RATE,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 uart_txd,
    output logic                 tx_done
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) || DIV < 2 ||
        CLK_FREQ <= 0 || BAUD_RATE <= 0) begin : g_bad_param
        $error("uart_tx_frame: illegal parameter set");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 bnd;

    assign bnd = cnt_q == CW'(DIV - 1);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (tx_valid && ready_q) begin
                state_d = START;
                shift_d = tx_data;
                par_d   = ^tx_data ^ (PARITY_ODD != 0);
                bit_d   = '0;
            end
            START: if (bnd) state_d = DATA;
            DATA: if (bnd) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 4'd1;
                if (bit_q == 4'(DATA_BITS - 1)) begin
                    bit_d   = '0;
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: if (bnd) state_d = STOP;
            STOP: if (bnd) begin
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'(STOP_BITS - 1)) begin
                    bit_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d   = (state_q == IDLE || bnd) ? '0 : cnt_q + CW'(1);
        // Outputs are registered, so they are decoded from the next state.
        txd_d   = (state_d == START)  ? 1'b0 :
                  (state_d == DATA)   ? shift_d[0] :
                  (state_d == PARITY) ? par_d : 1'b1;
        ready_d = state_d == IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready = ready_q;
    assign uart_txd = txd_q;
    assign tx_done  = done_q;
endmodule
